// File: rtl/traffic_lights_xing.sv
// rtl/traffic_lights_xing.sv - two-approach intersection controller with all-red clearance and blink mode
module traffic_lights_xing #(
    parameter int WIDTH                 = 16,
    parameter int CLK_PER_MS            = 1000,
    parameter int BLINK_HALF_PERIOD_MS  = 2,
    parameter int BLINK_GREEN_TIME_TICK = 5,
    parameter int RED_YELLOW_MS         = 10,
    parameter int ALL_RED_MS            = 4,
    parameter int DEF_GREEN_MS          = 20
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [2:0]       cmd_type_i,
    input  logic             cmd_valid_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic [1:0]       red_o,
    output logic [1:0]       yellow_o,
    output logic [1:0]       green_o,
    output logic [3:0]       phase_o
);

    localparam int CW    = WIDTH + 1;
    localparam int PW    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int BW    = (BLINK_HALF_PERIOD_MS > 1) ? $clog2(BLINK_HALF_PERIOD_MS) : 1;
    localparam int GB_MS = 2 * BLINK_HALF_PERIOD_MS * BLINK_GREEN_TIME_TICK;

    typedef enum logic [3:0] {
        PH_OFF   = 4'd0,
        PH_AR_A  = 4'd1,
        PH_A_RY  = 4'd2,
        PH_A_G   = 4'd3,
        PH_A_GB  = 4'd4,
        PH_A_Y   = 4'd5,
        PH_AR_B  = 4'd6,
        PH_B_RY  = 4'd7,
        PH_B_G   = 4'd8,
        PH_B_GB  = 4'd9,
        PH_B_Y   = 4'd10,
        PH_BLINK = 4'd11
    } phase_t;

    phase_t           phase_q, phase_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             blink_q, blink_d;
    logic [WIDTH-1:0] green_a_q, green_a_d;
    logic [WIDTH-1:0] green_b_q, green_b_d;
    logic [WIDTH-1:0] yellow_q, yellow_d;

    logic             tick;
    logic             in_ring;
    logic             phase_end;
    logic             restart;
    logic [CW-1:0]    dur;
    logic [WIDTH-1:0] set_val;

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            phase_q   <= PH_OFF;
            presc_q   <= '0;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            blink_q   <= 1'b0;
            green_a_q <= WIDTH'(DEF_GREEN_MS);
            green_b_q <= WIDTH'(DEF_GREEN_MS);
            yellow_q  <= WIDTH'(DEF_GREEN_MS);
        end else begin
            phase_q   <= phase_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            blink_q   <= blink_d;
            green_a_q <= green_a_d;
            green_b_q <= green_b_d;
            yellow_q  <= yellow_d;
        end
    end

    always_comb begin
        tick      = (presc_q == PW'(CLK_PER_MS - 1));
        in_ring   = (phase_q != PH_OFF) && (phase_q != PH_BLINK);
        set_val   = (cmd_data_i == '0) ? WIDTH'(1) : cmd_data_i;
        case (phase_q)
            PH_AR_A, PH_AR_B: dur = CW'(ALL_RED_MS);
            PH_A_RY, PH_B_RY: dur = CW'(RED_YELLOW_MS);
            PH_A_G:           dur = {1'b0, green_a_q};
            PH_B_G:           dur = {1'b0, green_b_q};
            PH_A_GB, PH_B_GB: dur = CW'(GB_MS);
            PH_A_Y, PH_B_Y:   dur = {1'b0, yellow_q};
            default:          dur = CW'(1);
        endcase
        phase_end = in_ring && tick && (cnt_q == dur - CW'(1));

        phase_d   = phase_q;
        restart   = 1'b0;
        green_a_d = green_a_q;
        green_b_d = green_b_q;
        yellow_d  = yellow_q;
        presc_d   = (phase_q == PH_OFF) ? '0 : (tick ? '0 : presc_q + PW'(1));
        cnt_d     = (in_ring && tick) ? cnt_q + CW'(1) : cnt_q;
        bcnt_d    = bcnt_q;
        blink_d   = blink_q;
        if (tick) begin
            if (bcnt_q == BW'(BLINK_HALF_PERIOD_MS - 1)) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end

        if (phase_q > PH_BLINK) begin
            phase_d = PH_OFF;
            restart = 1'b1;
        end else if (cmd_valid_i) begin
            case (cmd_type_i)
                3'd0: if (!in_ring) begin
                    phase_d = PH_AR_A;
                    restart = 1'b1;
                end
                3'd1: begin
                    phase_d = PH_OFF;
                    restart = 1'b1;
                end
                3'd2: begin
                    phase_d = PH_BLINK;
                    restart = 1'b1;
                end
                3'd3: if (phase_q == PH_BLINK) green_a_d = set_val;
                3'd4: if (phase_q == PH_BLINK) green_b_d = set_val;
                3'd5: if (phase_q == PH_BLINK) yellow_d = set_val;
                default: ;
            endcase
        end

        // An ignored command must not suppress the normal ring advance.
        if (!restart && phase_end) begin
            restart = 1'b1;
            case (phase_q)
                PH_AR_A: phase_d = PH_A_RY;
                PH_A_RY: phase_d = PH_A_G;
                PH_A_G:  phase_d = PH_A_GB;
                PH_A_GB: phase_d = PH_A_Y;
                PH_A_Y:  phase_d = PH_AR_B;
                PH_AR_B: phase_d = PH_B_RY;
                PH_B_RY: phase_d = PH_B_G;
                PH_B_G:  phase_d = PH_B_GB;
                PH_B_GB: phase_d = PH_B_Y;
                default: phase_d = PH_AR_A;
            endcase
        end

        if (restart) begin
            presc_d = '0;
            cnt_d   = '0;
            bcnt_d  = '0;
            blink_d = 1'b0;
        end
    end

    always_comb begin
        red_o    = 2'b00;
        yellow_o = 2'b00;
        green_o  = 2'b00;
        case (phase_q)
            PH_AR_A, PH_AR_B: red_o = 2'b11;
            PH_A_RY: begin red_o = 2'b11; yellow_o = 2'b01; end
            PH_A_G:  begin red_o = 2'b10; green_o  = 2'b01; end
            PH_A_GB: begin red_o = 2'b10; green_o  = {1'b0, ~blink_q}; end
            PH_A_Y:  begin red_o = 2'b10; yellow_o = 2'b01; end
            PH_B_RY: begin red_o = 2'b11; yellow_o = 2'b10; end
            PH_B_G:  begin red_o = 2'b01; green_o  = 2'b10; end
            PH_B_GB: begin red_o = 2'b01; green_o  = {~blink_q, 1'b0}; end
            PH_B_Y:  begin red_o = 2'b01; yellow_o = 2'b10; end
            PH_BLINK: yellow_o = {~blink_q, ~blink_q};
            default: ;
        endcase
    end

    assign phase_o = phase_q;

endmodule

// File: tb/tb_traffic_lights_xing.sv
// tb/tb_traffic_lights_xing.sv - directed scoreboard bench for traffic_lights_xing
module tb_traffic_lights_xing;

    logic        clk = 1'b0;
    logic        srst;
    logic [2:0]  cmd_type;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic [1:0]  red, yellow, green;
    logic [3:0]  phase;

    typedef struct packed {
        logic [3:0] p;
        logic [1:0] r;
        logic [1:0] y;
        logic [1:0] g;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   passed = 0;

    traffic_lights_xing #(
        .WIDTH(16), .CLK_PER_MS(2), .BLINK_HALF_PERIOD_MS(2), .BLINK_GREEN_TIME_TICK(5),
        .RED_YELLOW_MS(10), .ALL_RED_MS(4), .DEF_GREEN_MS(20)
    ) dut (
        .clk_i(clk), .srst_i(srst), .cmd_type_i(cmd_type), .cmd_valid_i(cmd_valid),
        .cmd_data_i(cmd_data), .red_o(red), .yellow_o(yellow), .green_o(green), .phase_o(phase)
    );

    always #5 clk = ~clk;

    task automatic expect_run(input string tag, input logic [3:0] p, input logic [1:0] r,
                              input logic [1:0] y, input logic [1:0] g, input int n);
        obs_t want, got;
        for (int i = 0; i < n; i++) begin
            q.push_back('{p: p, r: r, y: y, g: g});
            got  = '{p: phase, r: red, y: yellow, g: green};
            want = q.pop_front();
            checks++;
            assert (got === want) passed++;
            else $error("FAIL %s cycle %0d: got ph=%0d r=%b y=%b g=%b want ph=%0d r=%b y=%b g=%b",
                        tag, i, got.p, got.r, got.y, got.g, want.p, want.r, want.y, want.g);
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] d);
        cmd_type  = t;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic gb_run(input string tag, input logic [3:0] p, input logic [1:0] r,
                          input logic [1:0] g_on, input int pairs);
        for (int k = 0; k < pairs; k++) begin
            expect_run(tag, p, r, 2'b00, g_on, 4);
            expect_run(tag, p, r, 2'b00, 2'b00, 4);
        end
    endtask

    task automatic ring_to_a_g(input string tag);
        expect_run({tag, "_ar_a"}, 4'd1, 2'b11, 2'b00, 2'b00, 8);
        expect_run({tag, "_a_ry"}, 4'd2, 2'b11, 2'b01, 2'b00, 20);
    endtask

    initial begin
        srst = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        expect_run("reset", 4'd0, 2'b00, 2'b00, 2'b00, 1);
        srst = 1'b1;
        expect_run("idle_dark", 4'd0, 2'b00, 2'b00, 2'b00, 10);
        send(3'd6, 16'd5);
        expect_run("type6_ign", 4'd0, 2'b00, 2'b00, 2'b00, 2);
        send(3'd7, 16'd5);
        expect_run("type7_ign", 4'd0, 2'b00, 2'b00, 2'b00, 2);

        // Full default ring.
        send(3'd0, 16'd0);
        ring_to_a_g("ring1");
        expect_run("ring1_a_g", 4'd3, 2'b10, 2'b00, 2'b01, 40);
        gb_run("ring1_a_gb", 4'd4, 2'b10, 2'b01, 5);
        expect_run("ring1_a_y", 4'd5, 2'b10, 2'b01, 2'b00, 40);
        expect_run("ring1_ar_b", 4'd6, 2'b11, 2'b00, 2'b00, 8);
        expect_run("ring1_b_ry", 4'd7, 2'b11, 2'b10, 2'b00, 20);
        expect_run("ring1_b_g", 4'd8, 2'b01, 2'b00, 2'b10, 40);
        gb_run("ring1_b_gb", 4'd9, 2'b01, 2'b10, 5);
        expect_run("ring1_b_y", 4'd10, 2'b01, 2'b10, 2'b00, 40);
        expect_run("ring1_wrap", 4'd1, 2'b11, 2'b00, 2'b00, 1);

        // Blink mode and programming of times.
        send(3'd2, 16'd0);
        expect_run("blink_on", 4'd11, 2'b00, 2'b11, 2'b00, 4);
        expect_run("blink_off", 4'd11, 2'b00, 2'b00, 2'b00, 4);
        expect_run("blink_on2", 4'd11, 2'b00, 2'b11, 2'b00, 4);
        send(3'd3, 16'd3);
        send(3'd4, 16'd0);
        send(3'd0, 16'd0);
        ring_to_a_g("ring2");
        expect_run("ring2_a_g3", 4'd3, 2'b10, 2'b00, 2'b01, 6);
        gb_run("ring2_a_gb", 4'd4, 2'b10, 2'b01, 5);
        expect_run("ring2_a_y", 4'd5, 2'b10, 2'b01, 2'b00, 40);
        expect_run("ring2_ar_b", 4'd6, 2'b11, 2'b00, 2'b00, 8);
        expect_run("ring2_b_ry", 4'd7, 2'b11, 2'b10, 2'b00, 20);
        expect_run("ring2_b_g1", 4'd8, 2'b01, 2'b00, 2'b10, 2);
        expect_run("ring2_b_gb", 4'd9, 2'b01, 2'b00, 2'b10, 4);
        expect_run("ring2_b_gb", 4'd9, 2'b01, 2'b00, 2'b00, 4);

        // SET_YELLOW while NORMAL must be ignored and not disturb the ring.
        send(3'd5, 16'd1);
        expect_run("setyel_gb", 4'd9, 2'b01, 2'b00, 2'b10, 3);
        expect_run("setyel_gb", 4'd9, 2'b01, 2'b00, 2'b00, 4);
        gb_run("setyel_gb", 4'd9, 2'b01, 2'b10, 3);
        expect_run("setyel_b_y", 4'd10, 2'b01, 2'b10, 2'b00, 40);
        ring_to_a_g("ring3");
        expect_run("on_in_ag", 4'd3, 2'b10, 2'b00, 2'b01, 2);
        send(3'd0, 16'd0);
        expect_run("on_in_ag", 4'd3, 2'b10, 2'b00, 2'b01, 3);
        expect_run("off_pre", 4'd4, 2'b10, 2'b00, 2'b01, 4);
        send(3'd1, 16'd0);
        expect_run("off_dark", 4'd0, 2'b00, 2'b00, 2'b00, 3);

        // NOTRANSITION on the last cycle of A_G beats the ring advance.
        send(3'd0, 16'd0);
        ring_to_a_g("ring4");
        expect_run("ring4_a_g", 4'd3, 2'b10, 2'b00, 2'b01, 5);
        send(3'd2, 16'd0);
        expect_run("coinc_blink", 4'd11, 2'b00, 2'b11, 2'b00, 4);
        expect_run("coinc_blink", 4'd11, 2'b00, 2'b00, 2'b00, 4);
        expect_run("coinc_blink", 4'd11, 2'b00, 2'b11, 2'b00, 2);

        srst = 1'b0;
        @(posedge clk); #1;
        expect_run("reset_blink", 4'd0, 2'b00, 2'b00, 2'b00, 2);
        srst = 1'b1;
        send(3'd0, 16'd0);
        ring_to_a_g("ring5");
        expect_run("restored_a_g", 4'd3, 2'b10, 2'b00, 2'b01, 40);
        expect_run("restored_gb", 4'd4, 2'b10, 2'b00, 2'b01, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
